// File: rtl/uart_pkg.sv
// UART shared definitions: FSM states, control register bits, default baud.
// Used by uart_tx and the baud counter (and later uart_rx).
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int CTRL_TX_EN            = 0;
    localparam int CTRL_TX_SENDING       = 1;
    localparam int CTRL_RX_CONTAINS_DATA = 2;

    // 50 MHz / 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_baud_counter.sv
// Baud timer: counts 0..CLKS_PER_BIT-1 while run is high, ticks at terminal.
// Held at zero while run is low so each frame starts on a clean bit boundary.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = run && (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (!run || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with registered serial output and status pulses.
// A new frame may be accepted on the tx_done cycle for back-to-back sends.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_start,
    output logic       tx_sending,
    output logic       tx_done
);

    tx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_q, bit_d;
    logic       tx_q, tx_d;
    logic       start_q, start_d;
    logic       done_q, done_d;
    logic       run;
    logic       tick;

    assign run = (state_q != ST_IDLE);

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .run (run),
        .tick(tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                tx_d  = 1'b1;
                bit_d = 3'd0;
                if (tx_en) begin
                    state_d = ST_START;
                    shift_d = tx_data;
                    tx_d    = 1'b0;
                    start_d = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    // shift_q[0] is always the bit currently on the line
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= 8'h00;
            bit_q   <= 3'd0;
            tx_q    <= 1'b1;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            start_q <= start_d;
            done_q  <= done_d;
        end
    end

    assign tx         = tx_q;
    assign tx_start   = start_q;
    assign tx_sending = run;
    assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Randomized scoreboard bench for uart_tx at CLKS_PER_BIT=4.
// Driver predicts acceptances; monitor rebuilds the expected line per cycle.
module tb_uart_tx;

    localparam int C = 4;
    localparam int FRAME = 10 * C;

    typedef struct {
        int unsigned e;
        logic [7:0]  d;
    } acc_t;

    logic       clk;
    logic       rst;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       tx;
    logic       tx_start;
    logic       tx_sending;
    logic       tx_done;

    int unsigned cyc = 0;
    bit          rst_s = 1'b0;
    int unsigned next_free = 0;
    acc_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    bit          active = 1'b0;
    int unsigned s = 0;
    logic [7:0]  b = 8'h00;

    uart_tx #(
        .CLKS_PER_BIT(C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_en     (tx_en),
        .tx_data   (tx_data),
        .tx        (tx),
        .tx_start  (tx_start),
        .tx_sending(tx_sending),
        .tx_done   (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= rst;
    end

    task automatic chk(input string nm, input logic a, input logic e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, a, e);
        end
    endtask

    // Reference: a frame accepted at edge e occupies cycles e..e+FRAME-1,
    // tx_done appears at e+FRAME, and the next acceptance can be edge e+FRAME+1.
    task automatic step(input logic en, input logic [7:0] d, input logic r);
        int unsigned ed;
        acc_t a;
        rst     = r;
        tx_en   = en;
        tx_data = d;
        ed = cyc + 1;
        if (r) begin
            next_free = ed + 1;
        end else if (en && ed >= next_free) begin
            a.e = ed;
            a.d = d;
            q.push_back(a);
            next_free = ed + FRAME + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0);
    endtask

    always @(negedge clk) begin
        int unsigned off;
        int          bp;
        logic        etx, esend, estart, edone;
        acc_t        a;
        if (rst_s) active = 1'b0;
        if (q.size() > 0 && q[0].e == cyc) begin
            a      = q.pop_front();
            active = 1'b1;
            s      = cyc;
            b      = a.d;
        end
        etx = 1'b1;
        esend = 1'b0;
        estart = 1'b0;
        edone = 1'b0;
        if (active) begin
            off = cyc - s;
            if (off < FRAME) begin
                bp     = int'(off) / C;
                esend  = 1'b1;
                estart = (off == 0);
                if (bp == 0) etx = 1'b0;
                else if (bp <= 8) etx = b[bp-1];
                else etx = 1'b1;
            end else begin
                edone  = 1'b1;
                active = 1'b0;
            end
        end
        chk("tx", tx, etx);
        chk("tx_sending", tx_sending, esend);
        chk("tx_start", tx_start, estart);
        chk("tx_done", tx_done, edone);
    end

    initial begin
        rst     = 1'b1;
        tx_en   = 1'b0;
        tx_data = 8'h00;
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
        idle(100);

        // single frame, data changed to 0 mid-frame
        step(1'b1, 8'hA5, 1'b0);
        idle(15);
        for (int i = 0; i < 30; i++) step(1'b0, 8'h00, 1'b0);

        // back-to-back with tx_en held
        step(1'b1, 8'h01, 1'b0);
        for (int i = 0; i < 45; i++) step(1'b1, 8'hFF, 1'b0);
        idle(50);

        // tx_en pulsed while busy
        step(1'b1, 8'hA5, 1'b0);
        idle(15);
        step(1'b1, 8'h77, 1'b0);
        idle(40);

        // reset during data bit 3, then a clean frame
        step(1'b1, 8'h5A, 1'b0);
        idle(4 * C + 1);
        step(1'b1, 8'h99, 1'b1);
        idle(3);
        step(1'b1, 8'h3C, 1'b0);
        idle(45);

        for (int i = 0; i < 2500; i++) begin
            step($urandom_range(0, 19) == 0, 8'($urandom),
                 $urandom_range(0, 399) == 0);
        end
        idle(50);

        n_cmp++;
        if (q.size() != 0 || active) begin
            n_bad++;
            $display("FAIL drain pending=%0d active=%0d want=0/0",
                     q.size(), active);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
